// File: rtl/fpu_pkg.sv
// Shared definitions for the Bfloat16 FPU issue path: opcodes, funct5 codes,
// operation select encoding and issue FSM states.
package fpu_pkg;

    localparam logic [6:0] OPC_OP_FP  = 7'h53;
    localparam logic [6:0] OPC_FMADD  = 7'h43;
    localparam logic [6:0] OPC_FMSUB  = 7'h47;
    localparam logic [6:0] OPC_FNMSUB = 7'h4B;
    localparam logic [6:0] OPC_FNMADD = 7'h4F;

    localparam logic [4:0] F5_ADD     = 5'b00000;
    localparam logic [4:0] F5_SUB     = 5'b00001;
    localparam logic [4:0] F5_MUL     = 5'b00010;
    localparam logic [4:0] F5_DIV     = 5'b00011;
    localparam logic [4:0] F5_SQRT    = 5'b01011;
    localparam logic [4:0] F5_SGNJ    = 5'b00100;
    localparam logic [4:0] F5_MINMAX  = 5'b00101;
    localparam logic [4:0] F5_CMP     = 5'b10100;
    localparam logic [4:0] F5_CVT_W   = 5'b11000;
    localparam logic [4:0] F5_CVT_S_W = 5'b11010;
    localparam logic [4:0] F5_MV_X    = 5'b11100;
    localparam logic [4:0] F5_MV_W_X  = 5'b11110;

    localparam logic [2:0] RM_DYN       = 3'b111;
    localparam logic [2:0] RM_MAX_LEGAL = 3'b100;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_DIV     = 4'd3,
        OP_SQRT    = 4'd4,
        OP_SGNJ    = 4'd5,
        OP_MINMAX  = 4'd6,
        OP_CMP     = 4'd7,
        OP_CVT_W   = 4'd8,
        OP_CVT_S_W = 4'd9,
        OP_MV_X    = 4'd10,
        OP_MV_W_X  = 4'd11,
        OP_FMADD   = 4'd12,
        OP_FMSUB   = 4'd13,
        OP_FNMSUB  = 4'd14,
        OP_FNMADD  = 4'd15
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // A resolved rounding mode above RMM is reserved
    function automatic logic rm_is_legal(input logic [2:0] rm_res);
        return (rm_res <= RM_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational FP instruction decode: legality, op select, latency, rounding
// mode and destination file. fdiv/fsqrt decode only with FPU_DIV_SQRT_EN.
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_FMA  = 5,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic [31:0] i_instr,
    input  logic [2:0]  i_frm,
    output logic        o_legal,
    output op_sel_e     o_op_sel,
    output logic [3:0]  o_lat,
    output logic [2:0]  o_rm,
    output logic        o_wb_to_int
);

    logic [4:0] w_funct5;
    logic [2:0] w_rm_raw;
    logic       w_opc_ok;
    logic       w_unused;

    assign w_funct5 = i_instr[31:27];
    assign w_rm_raw = i_instr[14:12];
    assign o_rm     = (w_rm_raw == RM_DYN) ? i_frm : w_rm_raw;
    assign o_legal  = w_opc_ok & rm_is_legal(o_rm);
    assign w_unused = ^{i_instr[26:15], i_instr[11:7]};

`ifndef FPU_DIV_SQRT_EN
    logic [7:0] w_unused_lat;
    assign w_unused_lat = 8'(LAT_DIV) ^ 8'(LAT_SQRT);
`endif

    // Opcode / funct5 to operation, latency and destination file
    always_comb begin
        w_opc_ok    = 1'b1;
        o_op_sel    = OP_ADD;
        o_lat       = 4'(LAT_MISC);
        o_wb_to_int = 1'b0;
        case (i_instr[6:0])
            OPC_OP_FP: begin
                case (w_funct5)
                    F5_ADD:     begin o_op_sel = OP_ADD;  o_lat = 4'(LAT_ADD); end
                    F5_SUB:     begin o_op_sel = OP_SUB;  o_lat = 4'(LAT_ADD); end
                    F5_MUL:     begin o_op_sel = OP_MUL;  o_lat = 4'(LAT_MUL); end
`ifdef FPU_DIV_SQRT_EN
                    F5_DIV:     begin o_op_sel = OP_DIV;  o_lat = 4'(LAT_DIV); end
                    F5_SQRT:    begin o_op_sel = OP_SQRT; o_lat = 4'(LAT_SQRT); end
`endif
                    F5_SGNJ:    o_op_sel = OP_SGNJ;
                    F5_MINMAX:  o_op_sel = OP_MINMAX;
                    F5_CMP:     begin o_op_sel = OP_CMP;   o_wb_to_int = 1'b1; end
                    F5_CVT_W:   begin o_op_sel = OP_CVT_W; o_wb_to_int = 1'b1; end
                    F5_CVT_S_W: o_op_sel = OP_CVT_S_W;
                    F5_MV_X:    begin o_op_sel = OP_MV_X;  o_wb_to_int = 1'b1; end
                    F5_MV_W_X:  o_op_sel = OP_MV_W_X;
                    default:    w_opc_ok = 1'b0;
                endcase
            end
            OPC_FMADD:  begin o_op_sel = OP_FMADD;  o_lat = 4'(LAT_FMA); end
            OPC_FMSUB:  begin o_op_sel = OP_FMSUB;  o_lat = 4'(LAT_FMA); end
            OPC_FNMSUB: begin o_op_sel = OP_FNMSUB; o_lat = 4'(LAT_FMA); end
            OPC_FNMADD: begin o_op_sel = OP_FNMADD; o_lat = 4'(LAT_FMA); end
            default:    w_opc_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Bfloat16 FPU issue/sequencing controller: accepts flagged FP instructions,
// stalls the core, counts op latency and strobes writeback. Option: FPU_DIV_SQRT_EN.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_FMA  = 5,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [31:0] instr,
    input  logic        fpu_active,
    input  logic [2:0]  frm,
    output logic        halt_req,
    output logic        fpu_complete,
    output logic        op_valid,
    output logic [3:0]  op_sel,
    output logic [2:0]  rm_o,
    output logic [4:0]  rd_addr,
    output logic        wb_en,
    output logic        wb_to_int,
    output logic        illegal_inst,
    output logic        busy
);

    state_e     r_state;
    state_e     w_next_state;
    logic [3:0] r_cnt;
    logic       w_accept;
    logic       w_reject;

    logic       w_legal;
    op_sel_e    w_op_sel;
    logic [3:0] w_lat;
    logic [2:0] w_rm;
    logic       w_wb_to_int;

    op_sel_e    r_op_sel;
    logic [2:0] r_rm;
    logic [4:0] r_rd_addr;
    logic       r_wb_to_int;
    logic       r_op_valid;
    logic       r_complete;
    logic       r_wb_en;
    logic       r_illegal;

    fpu_op_decode #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_FMA  (LAT_FMA),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_MISC (LAT_MISC)
    ) u_decode (
        .i_instr     (instr),
        .i_frm       (frm),
        .o_legal     (w_legal),
        .o_op_sel    (w_op_sel),
        .o_lat       (w_lat),
        .o_rm        (w_rm),
        .o_wb_to_int (w_wb_to_int)
    );

    // Next-state and accept/reject decisions
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fpu_active && rst_l) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_EXEC;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_WB:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latency counter, strobes and latched op fields
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_cnt       <= 4'd0;
            r_op_sel    <= OP_ADD;
            r_rm        <= 3'd0;
            r_rd_addr   <= 5'd0;
            r_wb_to_int <= 1'b0;
            r_op_valid  <= 1'b0;
            r_complete  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_op_valid <= w_accept;
            r_illegal  <= w_reject;
            r_complete <= (w_next_state == ST_WB);
            r_wb_en    <= (w_next_state == ST_WB);
            if (w_accept) begin
                r_cnt       <= w_lat - 4'd1;
                r_op_sel    <= w_op_sel;
                r_rm        <= w_rm;
                r_rd_addr   <= instr[11:7];
                r_wb_to_int <= w_wb_to_int;
            end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign halt_req     = w_accept;
    assign busy         = (r_state != ST_IDLE);
    assign op_valid     = r_op_valid;
    assign fpu_complete = r_complete;
    assign wb_en        = r_wb_en;
    assign illegal_inst = r_illegal;
    assign op_sel       = r_op_sel;
    assign rm_o         = r_rm;
    assign rd_addr      = r_rd_addr;
    assign wb_to_int    = r_wb_to_int;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios then random traffic,
// checked every cycle against a schedule-based reference model.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int LAT_ADD  = 3;
    localparam int LAT_MUL  = 3;
    localparam int LAT_FMA  = 5;
    localparam int LAT_DIV  = 10;
    localparam int LAT_SQRT = 12;
    localparam int LAT_MISC = 1;

    logic        clk;
    logic        rst_l;
    logic [31:0] instr;
    logic        fpu_active;
    logic [2:0]  frm;
    logic        halt_req, fpu_complete, op_valid, wb_en, wb_to_int, illegal_inst, busy;
    logic [3:0]  op_sel;
    logic [2:0]  rm_o;
    logic [4:0]  rd_addr;

    int checks = 0;
    int errors = 0;

    // reference model: schedule of the last accepted op and last rejected decode
    int         tcur    = 0;
    int         acc_t   = -100;
    int         acc_lat = 0;
    int         ill_t   = -100;
    logic [3:0] e_op    = 4'd0;
    logic [2:0] e_rm    = 3'd0;
    logic [4:0] e_rd    = 5'd0;
    logic       e_int   = 1'b0;

    // per-funct5 tables for opcode 0x53
    bit         t_ok  [32];
    int         t_lat [32];
    logic [3:0] t_op  [32];
    bit         t_int [32];

    logic [6:0] fused_opc [4] = '{7'h43, 7'h47, 7'h4B, 7'h4F};
    logic [3:0] fused_op  [4] = '{OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD};
    logic [4:0] f5_list   [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b00100,
                                   5'b00101, 5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110};

    fpu_issue_ctrl dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .instr        (instr),
        .fpu_active   (fpu_active),
        .frm          (frm),
        .halt_req     (halt_req),
        .fpu_complete (fpu_complete),
        .op_valid     (op_valid),
        .op_sel       (op_sel),
        .rm_o         (rm_o),
        .rd_addr      (rd_addr),
        .wb_en        (wb_en),
        .wb_to_int    (wb_to_int),
        .illegal_inst (illegal_inst),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_entry(input int f5, input logic [3:0] op, input int lat, input bit toint);
        t_ok[f5]  = 1'b1;
        t_op[f5]  = op;
        t_lat[f5] = lat;
        t_int[f5] = toint;
    endtask

    task automatic init_tables();
        for (int i = 0; i < 32; i++) begin
            t_ok[i] = 1'b0; t_op[i] = 4'd0; t_lat[i] = 0; t_int[i] = 1'b0;
        end
        set_entry(5'b00000, OP_ADD,     LAT_ADD,  1'b0);
        set_entry(5'b00001, OP_SUB,     LAT_ADD,  1'b0);
        set_entry(5'b00010, OP_MUL,     LAT_MUL,  1'b0);
`ifdef FPU_DIV_SQRT_EN
        set_entry(5'b00011, OP_DIV,     LAT_DIV,  1'b0);
        set_entry(5'b01011, OP_SQRT,    LAT_SQRT, 1'b0);
`endif
        set_entry(5'b00100, OP_SGNJ,    LAT_MISC, 1'b0);
        set_entry(5'b00101, OP_MINMAX,  LAT_MISC, 1'b0);
        set_entry(5'b10100, OP_CMP,     LAT_MISC, 1'b1);
        set_entry(5'b11000, OP_CVT_W,   LAT_MISC, 1'b1);
        set_entry(5'b11010, OP_CVT_S_W, LAT_MISC, 1'b0);
        set_entry(5'b11100, OP_MV_X,    LAT_MISC, 1'b1);
        set_entry(5'b11110, OP_MV_W_X,  LAT_MISC, 1'b0);
    endtask

    task automatic m_decode(input logic [31:0] ins, input logic [2:0] f, output bit legal,
                            output int lat, output logic [3:0] op, output bit toint,
                            output logic [2:0] rm);
        bit known;
        known = 1'b0; lat = 0; op = 4'd0; toint = 1'b0;
        rm = (ins[14:12] == 3'd7) ? f : ins[14:12];
        if (ins[6:0] == 7'h53) begin
            known = t_ok[ins[31:27]];
            lat   = t_lat[ins[31:27]];
            op    = t_op[ins[31:27]];
            toint = t_int[ins[31:27]];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ins[6:0] == fused_opc[k]) begin
                    known = 1'b1; lat = LAT_FMA; op = fused_op[k];
                end
            end
        end
        legal = known && (rm <= 3'd4);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, tcur, obs, exp);
        end
    endtask

    // one clock cycle: check registered outputs, drive inputs, check halt_req, advance model
    task automatic cycle(input logic [31:0] ins, input logic act, input logic [2:0] f,
                         input logic rst);
        bit idle, legal, toint;
        int lat;
        logic [3:0] op;
        logic [2:0] rm;
        @(negedge clk);
        idle = !((acc_t < tcur) && (tcur <= acc_t + acc_lat + 1));
        chk("busy",         32'(busy),         32'(!idle));
        chk("op_valid",     32'(op_valid),     32'(tcur == acc_t + 1));
        chk("fpu_complete", 32'(fpu_complete), 32'(tcur == acc_t + acc_lat + 1));
        chk("wb_en",        32'(wb_en),        32'(tcur == acc_t + acc_lat + 1));
        chk("illegal_inst", 32'(illegal_inst), 32'(tcur == ill_t + 1));
        chk("op_sel",       32'(op_sel),       32'(e_op));
        chk("rm_o",         32'(rm_o),         32'(e_rm));
        chk("rd_addr",      32'(rd_addr),      32'(e_rd));
        chk("wb_to_int",    32'(wb_to_int),    32'(e_int));
        instr = ins; fpu_active = act; frm = f; rst_l = rst;
        #1;
        m_decode(ins, f, legal, lat, op, toint, rm);
        chk("halt_req", 32'(halt_req), 32'(rst && idle && act && legal));
        if (!rst) begin
            acc_t = -100; acc_lat = 0; ill_t = -100;
            e_op = 4'd0; e_rm = 3'd0; e_rd = 5'd0; e_int = 1'b0;
        end else if (idle && act) begin
            if (legal) begin
                acc_t = tcur; acc_lat = lat;
                e_op = op; e_rm = rm; e_rd = ins[11:7]; e_int = toint;
            end else begin
                ill_t = tcur;
            end
        end
        tcur++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 1'b0, 3'd0, 1'b1);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] f5,
                                       input logic [2:0] rm, input logic [4:0] rd);
        return {f5, 2'b00, 5'd2, 5'd1, rm, rd, opc};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc;
        logic [4:0]  f5;
        logic [2:0]  rm;
        init_tables();
        rst_l = 1'b0; fpu_active = 1'b0; instr = 32'h0; frm = 3'd0;
        repeat (3) @(posedge clk);

        idle_n(1);
        // fadd rd5: complete at T+4
        cycle(mk(7'h53, 5'b00000, 3'b000, 5'd5), 1'b1, 3'd0, 1'b1);
        idle_n(5);
        // fmadd, fadds ignored while busy, then accepted at T+7
        cycle(mk(7'h43, 5'b00011, 3'b001, 5'd9), 1'b1, 3'd0, 1'b1);
        repeat (6) cycle(mk(7'h53, 5'b00000, 3'b000, 5'd6), 1'b1, 3'd0, 1'b1);
        cycle(mk(7'h53, 5'b00000, 3'b000, 5'd6), 1'b1, 3'd0, 1'b1);
        idle_n(5);
        // dynamic rounding mode resolves to frm
        cycle(mk(7'h53, 5'b00010, 3'b111, 5'd3), 1'b1, 3'b010, 1'b1);
        idle_n(5);
        // reserved rm
        cycle(mk(7'h53, 5'b00000, 3'b101, 5'd8), 1'b1, 3'd0, 1'b1);
        idle_n(2);
        // dynamic rm with reserved frm
        cycle(mk(7'h53, 5'b00001, 3'b111, 5'd8), 1'b1, 3'b110, 1'b1);
        idle_n(2);
        // fdiv
        cycle(mk(7'h53, 5'b00011, 3'b000, 5'd4), 1'b1, 3'd0, 1'b1);
        idle_n(12);
        // abort during EXEC
`ifdef FPU_DIV_SQRT_EN
        cycle(mk(7'h53, 5'b01011, 3'b000, 5'd11), 1'b1, 3'd0, 1'b1);
`else
        cycle(mk(7'h4F, 5'b00000, 3'b000, 5'd11), 1'b1, 3'd0, 1'b1);
`endif
        idle_n(2);
        cycle(32'h0, 1'b0, 3'd0, 1'b0);
        idle_n(14);
        // feq to integer file
        cycle(mk(7'h53, 5'b10100, 3'b010, 5'd7), 1'b1, 3'd0, 1'b1);
        idle_n(3);

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                7:       opc = fused_opc[$urandom_range(0, 3)];
                8:       opc = 7'($urandom);
                default: opc = 7'h53;
            endcase
            f5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : f5_list[$urandom_range(0, 11)];
            rm = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
            ins = {f5, 2'($urandom), 10'($urandom), rm, 5'($urandom), opc};
            cycle(ins, 1'($urandom_range(0, 9) < 6), 3'($urandom),
                  1'($urandom_range(0, 59) != 0));
        end
        idle_n(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
